// File: rtl/vision_regs_pkg.sv
// Shared register map, CTRL field layout and identity constant for the vision pipeline blocks.
package vision_regs_pkg;

  localparam logic [1:0]  ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  ADDR_COUNT  = 2'd1;
  localparam logic [1:0]  ADDR_FRAMES = 2'd2;
  localparam logic [1:0]  ADDR_ID     = 2'd3;

  localparam int          CTRL_EN_BIT = 0;
  localparam int          CTRL_K_LSB  = 4;
  localparam int          CTRL_K_MSB  = 6;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h1234EE03;

  typedef struct packed {
    logic [2:0] k;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] w;
    w                        = 32'd0;
    w[CTRL_EN_BIT]           = c.en;
    w[CTRL_K_MSB:CTRL_K_LSB] = c.k;
    return w;
  endfunction

  // A window length of zero behaves as one.
  function automatic logic [2:0] eff_k(input logic [2:0] k);
    return (k == 3'd0) ? 3'd1 : k;
  endfunction

endpackage

// File: rtl/erode_run.sv
// Causal 1xK horizontal erosion: tracks the run of consecutive on pixels in the current row.
module erode_run
  import vision_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_adv,
  input  logic       i_on,
  input  logic       i_x_zero,
  input  logic [2:0] i_k,
  output logic       o_bit
);

  logic [2:0] r_run;
  logic [2:0] w_run_base;
  logic [2:0] w_run_new;

  // Next run length, saturating at 7 and restarting at each row start.
  always_comb begin
    w_run_base = i_x_zero ? 3'd0 : r_run;
    if (!i_on) begin
      w_run_new = 3'd0;
    end else if (w_run_base == 3'd7) begin
      w_run_new = 3'd7;
    end else begin
      w_run_new = w_run_base + 3'd1;
    end
    o_bit = i_on & (w_run_new >= eff_k(i_k));
  end

  // Run length state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_run <= 3'd0;
    end else if (i_clr) begin
      r_run <= 3'd0;
    end else if (i_adv) begin
      r_run <= w_run_new;
    end
  end

endmodule

// File: rtl/stream_erode.sv
// Avalon-ST mask-video erosion stage with shadowed CTRL, per-frame on-pixel COUNT and FRAMES counter.
module stream_erode
  import vision_regs_pkg::*;
#(
  parameter int          IMAGE_W  = 640,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [1:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
);

  localparam logic [10:0] X_LAST = 11'(IMAGE_W - 1);

  logic        r_src_valid, r_src_sop, r_src_eop;
  logic [23:0] r_src_data;
  logic [31:0] r_readdata;
  ctrl_t       r_ctrl, r_act;
  logic        r_in_pkt, r_is_video;
  logic [10:0] r_x;
  logic [31:0] r_cnt, r_count;
  logic [15:0] r_frames;

  logic        w_sink_ready, w_accept, w_sop_acc, w_fwd, w_pix, w_eop_vid;
  logic        w_erode_bit, w_out_on;
  logic [23:0] w_out_data;
  logic [31:0] w_cnt_next, w_rdata;
  logic        w_unused;

  assign w_sink_ready = ~r_src_valid | source_ready;
  assign w_accept     = sink_valid & w_sink_ready;
  assign w_sop_acc    = w_accept & sink_sop;
  // Beats outside a packet (e.g. after a mid-packet reset) are consumed and dropped.
  assign w_fwd        = w_accept & (sink_sop | r_in_pkt);
  assign w_pix        = w_accept & ~sink_sop & r_in_pkt & r_is_video;
  assign w_eop_vid    = w_pix & sink_eop;
  assign w_out_on     = w_pix & w_out_data[23];
  assign w_cnt_next   = r_cnt + {31'd0, w_out_on};
  assign w_unused     = ^{s_writedata[31:7], s_writedata[3:1]};

  erode_run u_erode_run (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_sop_acc),
    .i_adv    (w_pix),
    .i_on     (sink_data[23]),
    .i_x_zero (r_x == 11'd0),
    .i_k      (r_act.k),
    .o_bit    (w_erode_bit)
  );

  // Output pixel selection: eroded mask for enabled video pixels, passthrough otherwise.
  always_comb begin
    if (w_pix && r_act.en) begin
      w_out_data = w_erode_bit ? 24'hFFFFFF : 24'h000000;
    end else begin
      w_out_data = sink_data;
    end
  end

  // Output beat register and packet/frame state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_src_data  <= 24'd0;
      r_act       <= '0;
      r_in_pkt    <= 1'b0;
      r_is_video  <= 1'b0;
      r_x         <= 11'd0;
      r_cnt       <= 32'd0;
      r_count     <= 32'd0;
      r_frames    <= 16'd0;
    end else begin
      if (w_fwd) begin
        r_src_valid <= 1'b1;
        r_src_data  <= w_out_data;
        r_src_sop   <= sink_sop;
        r_src_eop   <= sink_eop;
      end else if (source_ready) begin
        r_src_valid <= 1'b0;
      end
      if (w_sop_acc) begin
        r_in_pkt   <= ~sink_eop;
        r_is_video <= (sink_data[3:0] == 4'h0);
        r_act      <= r_ctrl;
        r_x        <= 11'd0;
        r_cnt      <= 32'd0;
      end else if (w_accept && r_in_pkt) begin
        if (sink_eop) begin
          r_in_pkt <= 1'b0;
        end
        if (w_pix) begin
          r_x   <= (r_x == X_LAST) ? 11'd0 : r_x + 11'd1;
          r_cnt <= w_cnt_next;
        end
        if (w_eop_vid) begin
          r_count  <= w_cnt_next;
          r_frames <= r_frames + 16'd1;
        end
      end
    end
  end

  // Register read mux.
  always_comb begin
    w_rdata = 32'd0;
    case (s_address)
      ADDR_CTRL:   w_rdata = ctrl_pack(r_ctrl);
      ADDR_COUNT:  w_rdata = r_count;
      ADDR_FRAMES: w_rdata = {16'd0, r_frames};
      ADDR_ID:     w_rdata = ID_VALUE;
      default:     w_rdata = 32'd0;
    endcase
  end

  // CTRL write and registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl     <= '0;
      r_readdata <= 32'd0;
    end else begin
      if (s_chipselect && s_write && (s_address == ADDR_CTRL)) begin
        r_ctrl.en <= s_writedata[CTRL_EN_BIT];
        r_ctrl.k  <= s_writedata[CTRL_K_MSB:CTRL_K_LSB];
      end
      if (s_chipselect && s_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign sink_ready   = w_sink_ready;
  assign source_valid = r_src_valid;
  assign source_data  = r_src_data;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;
  assign s_readdata   = r_readdata;

endmodule

// File: tb/tb_stream_erode.sv
// Scoreboard bench for stream_erode: directed frames with hand-computed expected beats and registers.
module tb_stream_erode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [23:0] source_data;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic        s_chipselect, s_read, s_write;
  logic [1:0]  s_address;
  logic [31:0] s_writedata, s_readdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [25:0] sb_q[$];
  bit          sb_push  = 1'b1;
  bit          held     = 1'b0;
  logic [25:0] held_val;

  bit t25_in  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit t25_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [23:0] t28_beats [4] = '{24'hFFFFFF, 24'h000000, 24'h80FF00, 24'hABCDEF};

  always #5 clk = ~clk;

  stream_erode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] px(input bit b);
    return b ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic send(input logic [23:0] d, input logic sop, input logic eop, input logic [23:0] exp);
    bit acc;
    int guard;
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_valid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    else if (sb_push) sb_q.push_back({exp, sop, eop});
  endtask

  task automatic idle();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = v;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_read = 1'b0;
    check(name, s_readdata, exp);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks held beats stay stable.
  always @(negedge clk) begin
    if (reset_n && source_valid) begin
      if (held) check("hold_stable", {6'd0, source_data, source_sop, source_eop}, {6'd0, held_val});
      if (source_ready) begin
        held = 1'b0;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", {6'd0, source_data, source_sop, source_eop}, 32'hFFFFFFFF);
        end else begin
          check("beat", {6'd0, source_data, source_sop, source_eop}, {6'd0, sb_q.pop_front()});
        end
      end else begin
        held     = 1'b1;
        held_val = {source_data, source_sop, source_eop};
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; source_ready = 1'b1;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = 2'd0; s_writedata = 32'd0;
    sink_data = 24'd0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_valid", {31'd0, source_valid}, 32'd0);
    check("rst_src_data", {8'd0, source_data}, 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;
    rd_check("rst_ctrl", 2'd0, 32'd0);
    rd_check("rst_count", 2'd1, 32'd0);
    rd_check("rst_frames", 2'd2, 32'd0);
    rd_check("id", 2'd3, 32'h1234EE03);

    // Basic 1x3 erosion on a short row.
    wr(2'd0, 32'h0000_0031);
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 8; i++) send(px(t25_in[i]), 1'b0, (i == 7), px(t25_exp[i]));
    idle();
    drain();
    rd_check("t25_count", 2'd1, 32'd2);
    rd_check("t25_frames", 2'd2, 32'd1);

    // Run crossing a row boundary restarts at x=0.
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int x = 0; x < 640; x++) send(px(x >= 634), 1'b0, 1'b0, px(x >= 636));
    send(24'hFFFFFF, 1'b0, 1'b0, 24'h000000);
    send(24'hFFFFFF, 1'b0, 1'b0, 24'h000000);
    send(24'h000000, 1'b0, 1'b1, 24'h000000);
    idle();
    drain();
    rd_check("t26_count", 2'd1, 32'd4);
    rd_check("t26_frames", 2'd2, 32'd2);

    // Backpressure: four cycles of source_ready low in mid-frame.
    wr(2'd0, 32'h0000_0011);
    fork
      begin
        send(24'h000000, 1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 20; i++) send(px(i % 3 != 0), 1'b0, (i == 19), px(i % 3 != 0));
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        #1 source_ready = 1'b0;
        @(negedge clk);
        check("stall_sink_ready", {31'd0, sink_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1 source_ready = 1'b1;
      end
    join
    drain();
    rd_check("t27_count", 2'd1, 32'd13);
    rd_check("t27_frames", 2'd2, 32'd3);

    // Non-video packet passes bit-exact and leaves the counters alone.
    wr(2'd0, 32'h0000_0031);
    send(24'h00000F, 1'b1, 1'b0, 24'h00000F);
    for (int i = 0; i < 4; i++) send(t28_beats[i], 1'b0, (i == 3), t28_beats[i]);
    idle();
    drain();
    rd_check("t28_count", 2'd1, 32'd13);
    rd_check("t28_frames", 2'd2, 32'd3);

    // CTRL written mid-frame only takes effect at the next SOP.
    wr(2'd0, 32'h0000_0021);
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 5; i++) send(24'hFFFFFF, 1'b0, 1'b0, px(i != 0));
    idle();
    wr(2'd0, 32'h0000_0071);
    rd_check("t29_ctrl", 2'd0, 32'h0000_0071);
    for (int i = 5; i < 10; i++) send(24'hFFFFFF, 1'b0, (i == 9), 24'hFFFFFF);
    idle();
    drain();
    rd_check("t29a_count", 2'd1, 32'd9);
    rd_check("t29a_frames", 2'd2, 32'd4);
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 10; i++) send(24'hFFFFFF, 1'b0, (i == 9), px(i >= 6));
    idle();
    drain();
    rd_check("t29b_count", 2'd1, 32'd4);
    rd_check("t29b_frames", 2'd2, 32'd5);

    // Full-white 640x48 frame with K=1.
    wr(2'd0, 32'h0000_0011);
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 640 * 48; i++) send(24'hFFFFFF, 1'b0, (i == 640 * 48 - 1), 24'hFFFFFF);
    idle();
    drain();
    rd_check("white_count", 2'd1, 32'd30720);
    rd_check("white_frames", 2'd2, 32'd6);

    // Reset with a beat held in the output register.
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 3; i++) send(24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF);
    idle();
    drain();
    sb_push = 1'b0;
    source_ready = 1'b0;
    send(24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF);
    idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_mid_valid", {31'd0, source_valid}, 32'd0);
    source_ready = 1'b1;
    rd_check("rst_mid_ctrl", 2'd0, 32'd0);
    rd_check("rst_mid_count", 2'd1, 32'd0);
    rd_check("rst_mid_frames", 2'd2, 32'd0);
    rd_check("rst_mid_id", 2'd3, 32'h1234EE03);
    send(24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("stray_dropped", {31'd0, source_valid}, 32'd0);
    sb_push = 1'b1;
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    send(24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF);
    send(24'h000000, 1'b0, 1'b0, 24'h000000);
    send(24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFF);
    idle();
    drain();
    rd_check("fresh_count", 2'd1, 32'd2);
    rd_check("fresh_frames", 2'd2, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
